// File: rtl/rf_pkg.sv
// Shared constants and helpers for the parametrised register file.
//   RF_DATA_W / RF_DEPTH / RF_NUM_RD : default geometry (32 x 32-bit, 2 read ports)
//   RF_MAX_DEPTH                     : widest busy vector rf_popcount accepts
//   rf_popcount                      : number of set bits in a busy vector
package rf_pkg;

    localparam int unsigned RF_DATA_W    = 32;
    localparam int unsigned RF_DEPTH     = 32;
    localparam int unsigned RF_NUM_RD    = 2;
    localparam int unsigned RF_MAX_DEPTH = 256;

    // Callers zero-extend their busy vector to RF_MAX_DEPTH bits.
    function automatic int unsigned rf_popcount(input logic [RF_MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < RF_MAX_DEPTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the register file.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   write_i, waddr_i  : writeback, clears busy[waddr_i]
//   issue_i, iaddr_i  : decode issue, sets busy[iaddr_i]
//   flush_i           : clears every busy bit
//   busy_q_o          : current busy vector
//   busy_d_o          : busy vector after the coming edge (used for bypass)
//   cnt_o             : registered popcount of busy_q_o
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    input  logic              flush_i,
    output logic [DEPTH-1:0]  busy_q_o,
    output logic [DEPTH-1:0]  busy_d_o,
    output logic [ADDR_W:0]   cnt_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q;
    logic             write_ok, issue_ok;

    assign write_ok = write_i && !(ZERO_REG && (waddr_i == '0));
    assign issue_ok = issue_i && !(ZERO_REG && (iaddr_i == '0));

    // Order sets priority: write clears, a same-address issue re-sets
    // (newer producer wins), flush and reset override everything.
    always_comb begin
        busy_d = busy_q;
        if (write_ok) busy_d[waddr_i] = 1'b0;
        if (issue_ok) busy_d[iaddr_i] = 1'b1;
        if (flush_i)  busy_d = '0;
        if (rst_i)    busy_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= CNT_W'(rf_popcount(RF_MAX_DEPTH'(busy_d)));
        end
    end

    assign busy_q_o = busy_q;
    assign busy_d_o = busy_d;
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with same-cycle bypass and busy scoreboard.
//   CLK, RESET         : clock, synchronous active-high reset
//   IN, INADDRESS      : write data / address, stored when WRITE=1
//   ISSUE, ISSUE_ADDR  : mark a destination register busy
//   FLUSH              : clear all busy bits, contents kept
//   RADDR              : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RDATA              : packed read data, port k at [k*DATA_W +: DATA_W]
//   RBUSY              : busy flag of each port's addressed register
//   BUSY_CNT           : registered count of busy registers
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = RF_NUM_RD,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_W-1:0]        IN,
    input  logic [ADDR_W-1:0]        INADDRESS,
    input  logic                     WRITE,
    input  logic                     ISSUE,
    input  logic [ADDR_W-1:0]        ISSUE_ADDR,
    input  logic                     FLUSH,
    input  logic [NUM_RD*ADDR_W-1:0] RADDR,
    output logic [NUM_RD*DATA_W-1:0] RDATA,
    output logic [NUM_RD-1:0]        RBUSY,
    output logic [ADDR_W:0]          BUSY_CNT
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              wr_en;

    assign wr_en = WRITE && !(ZERO_REG && (INADDRESS == '0));

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .write_i  (WRITE),
        .waddr_i  (INADDRESS),
        .issue_i  (ISSUE),
        .iaddr_i  (ISSUE_ADDR),
        .flush_i  (FLUSH),
        .busy_q_o (busy_q),
        .busy_d_o (busy_d),
        .cnt_o    (BUSY_CNT)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[INADDRESS] <= IN;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = RADDR[k*ADDR_W +: ADDR_W];

        // wr_en already excludes discarded zero writes, so bypass never
        // fires for register 0 when it is hardwired.
        always_comb begin
            data = regs_q[addr];
            busy = busy_q[addr];
            if (BYPASS && wr_en && (INADDRESS == addr)) begin
                data = IN;
                busy = busy_d[addr];
            end
            if (RESET || (ZERO_REG && (addr == '0))) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign RDATA[k*DATA_W +: DATA_W] = data;
        assign RBUSY[k] = busy;
    end

endmodule
